seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for an NDIGITS-wide common-cathode/anode 7-segment display.
- Holds a hex value as one nibble per digit and scans the digits with a programmable refresh prescaler.
- Inserts a dead-time at the start of each digit slot to suppress ghosting, and applies optional leading-zero blanking.
- Display data is double-buffered so that a new value takes effect only at a frame boundary, which avoids tearing.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/hex7seg_dec.sv | 10 +
 rtl/seg7_scan_driver.sv | 114 +++++++++++
 tb/tb_seg7_scan_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver:
// hex-to-segment table, blank pattern and pin polarity mapping.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Index is the nibble value; bit6..bit0 = g..a.
    localparam logic [6:0] HEX2SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Maps logical {dp, segments} (1 = lit) onto the pin levels.
    function automatic logic [7:0] seg_pins(input logic [6:0] seg,
                                            input logic       dp_on,
                                            input logic       active_low);
        return active_low ? ~{dp_on, seg} : {dp_on, seg};
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to 7-segment decode (logical polarity, 1 = lit).
module hex7seg_dec (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    assign seg = HEX2SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver: double-buffered hex value, per-slot
// dead time, leading-zero blanking and registered pin outputs.
module seg7_scan_driver #(
    parameter int NDIGITS        = 4,
    parameter int DIV            = 50000,
    parameter int DEAD           = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   blank_lz,
    output logic [6:0]             led7s,
    output logic                   dp,
    output logic [NDIGITS-1:0]     dig_sel,
    output logic                   frame_done
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NDIGITS);
    localparam logic [7:0]         PINS_OFF = seg_pins(SEG_OFF, 1'b0, SEG_ACTIVE_LOW);
    localparam logic [NDIGITS-1:0] SEL_OFF  = {NDIGITS{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [4*NDIGITS-1:0] shadow_val, active_val;
    logic [NDIGITS-1:0]   shadow_dp, active_dp;

    logic                 slot_end, frame_end, lit, lz_blank;
    logic [3:0]           cur_nib;
    logic [6:0]           dec_seg, seg_nxt;
    logic                 dp_nxt;
    logic [NDIGITS-1:0]   sel_nxt;
    logic [7:0]           pins_nxt;

    assign slot_end  = (cnt == CNT_W'(DIV - 1));
    assign frame_end = enable && slot_end && (idx == IDX_W'(NDIGITS - 1));
    assign cur_nib   = active_val[{idx, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = blank_lz && (idx != '0);
        for (int i = 0; i < NDIGITS; i++) begin
            if (IDX_W'(i) >= idx && active_val[4*i +: 4] != 4'h0)
                lz_blank = 1'b0;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        lit     = enable && (cnt >= CNT_W'(DEAD));
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b0;
        sel_nxt = '0;
        if (lit) begin
            sel_nxt = NDIGITS'(1) << idx;
            seg_nxt = lz_blank ? SEG_OFF : dec_seg;
            dp_nxt  = active_dp[idx];
        end
        pins_nxt = seg_pins(seg_nxt, dp_nxt, SEG_ACTIVE_LOW);
    end

    // NOTE: state uses non-blocking assignments so all registers update from
    // pre-edge values; the display buffers are ordinary flops and are cleared
    // by reset so the panel shows zeros rather than power-up garbage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            frame_done <= 1'b0;
            {dp, led7s} <= PINS_OFF;
            dig_sel    <= SEL_OFF;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end

            if (!enable) begin
                cnt <= '0;
                idx <= '0;
            end else begin
                cnt <= slot_end ? '0 : cnt + CNT_W'(1);
                if (slot_end)
                    idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end

            // A load landing on the boundary itself bypasses the shadow copy.
            if (frame_end) begin
                active_val <= load ? value : shadow_val;
                active_dp  <= load ? dp_in : shadow_dp;
            end

            frame_done  <= frame_end;
            {dp, led7s} <= pins_nxt;
            dig_sel     <= DIG_ACTIVE_LOW ? ~sel_nxt : sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NDIGITS=4, DIV=8, DEAD=2,
// segment pins active-high and digit selects active-low.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0   = 7'b0111111;
    localparam logic [6:0] S1   = 7'b0000110;
    localparam logic [6:0] S2   = 7'b1011011;
    localparam logic [6:0] S4   = 7'b1100110;
    localparam logic [6:0] S5   = 7'b1101101;
    localparam logic [6:0] S9   = 7'b1101111;
    localparam logic [6:0] SA   = 7'b1110111;
    localparam logic [6:0] SE   = 7'b1111001;
    localparam logic [6:0] SF   = 7'b1110001;
    localparam logic [6:0] SOFF = 7'b0000000;
    localparam logic [12:0] ALL_OFF = {4'b1111, 7'b0000000, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  led7s;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    // {dig_sel, led7s, dp, frame_done} captured at each falling edge.
    logic [12:0] cap [32];
    logic [12:0] exp_v;
    logic [12:0] obs_v;

    seg7_scan_driver #(
        .NDIGITS(4), .DIV(8), .DEAD(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .led7s      (led7s),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected pins at sample j of a frame aligned to digit 0, cnt 0.
    // segs = {digit3, digit2, digit1, digit0}.
    function automatic logic [12:0] frame_exp(input int j, input logic [27:0] segs,
                                              input logic [3:0] dps);
        int   slot;
        int   pos;
        logic fd;
        slot = j / 8;
        pos  = j % 8;
        fd   = (j == 31);
        if (pos < 2)
            return {4'b1111, 7'b0000000, 1'b0, fd};
        return {~(4'b0001 << slot), segs[slot*7 +: 7], dps[slot], fd};
    endfunction

    // Samples one full frame; optionally pulses load after sample load_at.
    task automatic capture_frame(input int load_at, input logic [15:0] v, input logic [3:0] d);
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            cap[j] = {dig_sel, led7s, dp, frame_done};
            if (j == load_at) begin
                load  = 1'b1;
                value = v;
                dp_in = d;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs_v = {dig_sel, led7s, dp, frame_done};
            vectors++;
            if (obs_v !== ALL_OFF) begin
                miscompares++;
                $display("FAIL reset_off[%0d]: got %b want %b", k, obs_v, ALL_OFF);
            end
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        capture_frame(-1, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S0, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL basic_scan[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    task automatic test_load_buffering;
        capture_frame(10, 16'h12AF, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S0, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL load_held[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
        capture_frame(-1, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S1, S2, SA, SF}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL load_shown[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    task automatic test_blanking;
        blank_lz = 1'b1;
        capture_frame(5, 16'h0040, 4'b1000);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S1, S2, SA, SF}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL lz_nozero[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
        capture_frame(5, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {SOFF, SOFF, S4, S0}, 4'b1000);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL lz_0040[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
        capture_frame(-1, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {SOFF, SOFF, SOFF, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL lz_0000[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    task automatic test_boundary_load;
        blank_lz = 1'b0;
        capture_frame(30, 16'hE000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S0, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL bnd_before[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
        capture_frame(-1, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {SE, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL bnd_bypass[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    task automatic test_enable_drop;
        // Drop at idx=2/cnt=5, load 5000 while idle, resume after 4 cycles.
        for (int j = 0; j < 57; j++) begin
            @(negedge clk);
            obs_v = {dig_sel, led7s, dp, frame_done};
            if (j <= 20)
                exp_v = frame_exp(j, {SE, S0, S0, S0}, 4'h0);
            else if (j <= 24)
                exp_v = ALL_OFF;
            else
                exp_v = frame_exp(j - 25, {SE, S0, S0, S0}, 4'h0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL en_drop[%0d]: got %b want %b", j, obs_v, exp_v);
            end
            if (j == 20) enable = 1'b0;
            if (j == 22) begin
                load  = 1'b1;
                value = 16'h5000;
            end
            if (j == 23) load = 1'b0;
            if (j == 24) enable = 1'b1;
        end
        capture_frame(3, 16'h9999, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S5, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL en_shadow[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            obs_v = {dig_sel, led7s, dp, frame_done};
            exp_v = frame_exp(j, {S9, S9, S9, S9}, 4'h0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL pre_reset[%0d]: got %b want %b", j, obs_v, exp_v);
            end
        end
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs_v = {dig_sel, led7s, dp, frame_done};
            vectors++;
            if (obs_v !== ALL_OFF) begin
                miscompares++;
                $display("FAIL mid_reset[%0d]: got %b want %b", k, obs_v, ALL_OFF);
            end
        end
        rst_n = 1'b1;
        capture_frame(-1, 16'h0000, 4'h0);
        for (int j = 0; j < 32; j++) begin
            exp_v = frame_exp(j, {S0, S0, S0, S0}, 4'h0);
            vectors++;
            if (cap[j] !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got %b want %b", j, cap[j], exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_buffering();
        test_blanking();
        test_boundary_load();
        test_enable_drop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
